// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : RV64 fetch stage; one outstanding I-mem read, single-entry
//            instruction buffer, execute-driven redirect with stale-drop.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic [63:0] inst_count
);

    localparam logic [63:0] PC_STEP       = 64'd4;
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [63:0] pc_buf;
    logic [63:0] pc_buf_nxt;
    logic [31:0] inst_buf;
    logic [31:0] inst_buf_nxt;
    logic        drop;
    logic        drop_nxt;
    logic [63:0] count_nxt;

    // Request is gated by rst_n so nothing is offered to memory while in reset.
    assign imem_req_valid = (state == ST_REQ) && rst_n;
    assign imem_req_addr  = pc;
    assign out_valid      = (state == ST_HOLD);
    assign out_inst       = inst_buf;
    assign out_pc         = pc_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            pc_buf     <= 64'd0;
            inst_buf   <= 32'd0;
            drop       <= 1'b0;
            inst_count <= 64'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc_buf     <= pc_buf_nxt;
            inst_buf   <= inst_buf_nxt;
            drop       <= drop_nxt;
            inst_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pc_buf_nxt   = pc_buf;
        inst_buf_nxt = inst_buf;
        drop_nxt     = drop;
        count_nxt    = inst_count;

        case (state)
            ST_REQ: begin
                if (imem_req_ready) begin
                    pc_buf_nxt = pc;
                    state_nxt  = ST_WAIT;
                    // Old-PC request already left; its response must be discarded.
                    drop_nxt   = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = ST_REQ;
                    end else begin
                        inst_buf_nxt = imem_rsp_data;
                        state_nxt    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    state_nxt = ST_REQ;
                end else if (out_ready) begin
                    pc_nxt    = pc_buf + PC_STEP;
                    count_nxt = inst_count + 64'd1;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase

        // Redirect overrides every other PC update in any state.
        if (redirect_valid) begin
            pc_nxt = redirect_target & PC_ALIGN_MASK;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Randomized bench for inst_fetch against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [63:0] inst_count;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .inst_count      (inst_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural view: an outstanding read (possibly stale), a held
    // instruction awaiting decode, the next fetch PC and the handoff count.
    bit          m_busy;
    bit          m_stale;
    bit          m_held;
    logic [63:0] m_pc;
    logic [63:0] m_req_addr;
    logic [63:0] m_hold_pc;
    logic [31:0] m_hold_inst;
    logic [63:0] m_count;

    // Memory: one slot with a random latency countdown.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data_q;

    int          p_ready     = 100;
    int          p_out_ready = 100;
    int          p_redir     = 0;
    int          p_stray     = 0;
    int          lat_min     = 1;
    int          lat_max     = 1;
    bit          fixed_data  = 1'b1;
    int          ov_ready     = -1;
    int          ov_out_ready = -1;
    int          ov_redir     = -1;
    logic [63:0] ov_target    = 64'd0;

    task automatic check_outputs();
        bit exp_req;
        exp_req = !m_busy && !m_held;
        check_val("req_valid", imem_req_valid, exp_req);
        if (exp_req) check_val("req_addr", imem_req_addr, m_pc);
        check_val("out_valid", out_valid, m_held);
        if (m_held) begin
            check_val("out_inst", out_inst, m_hold_inst);
            check_val("out_pc", out_pc, m_hold_pc);
        end
        check_val("inst_count", inst_count, m_count);
    endtask

    task automatic drive_inputs();
        imem_req_ready = (ov_ready >= 0) ? ov_ready[0] : ($urandom_range(99) < p_ready);
        out_ready      = (ov_out_ready >= 0) ? ov_out_ready[0] : ($urandom_range(99) < p_out_ready);
        if (ov_redir >= 0) begin
            redirect_valid  = ov_redir[0];
            redirect_target = ov_target;
        end else begin
            redirect_valid  = ($urandom_range(99) < p_redir);
            redirect_target = ($urandom_range(1) == 0) ? (RESET_PC + 64'($urandom_range(4095)))
                                                      : {$urandom, $urandom};
        end
        if (mem_busy && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data_q;
        end else if (!mem_busy && $urandom_range(99) < p_stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Applies the effect of the coming rising edge, using pre-edge values.
    task automatic model_edge();
        bit          redir;
        bit          acc;
        logic [63:0] tgt;
        logic [63:0] old_pc;
        redir  = redirect_valid;
        tgt    = {redirect_target[63:2], 2'b00};
        acc    = !m_busy && !m_held && imem_req_ready;
        old_pc = m_pc;

        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_busy   = 1'b1;
            mem_cnt    = $urandom_range(lat_max, lat_min) - 1;
            mem_data_q = fixed_data ? 32'h0000_0013 : $urandom;
        end

        if (m_held && (redir || out_ready)) begin
            if (!redir) begin
                m_count = m_count + 64'd1;
                m_pc    = m_hold_pc + 64'd4;
            end
            m_held = 1'b0;
        end
        if (m_busy && imem_rsp_valid) begin
            m_busy = 1'b0;
            if (!m_stale && !redir) begin
                m_held      = 1'b1;
                m_hold_inst = imem_rsp_data;
                m_hold_pc   = m_req_addr;
            end
        end else if (m_busy && redir) begin
            m_stale = 1'b1;
        end
        if (acc) begin
            m_busy     = 1'b1;
            m_stale    = redir;
            m_req_addr = old_pc;
        end
        if (redir) m_pc = tgt;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_inputs();
        model_edge();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0:       return m_held;
            1:       return m_busy;
            2:       return !m_busy && !m_held;
            default: return (m_count == 64'd7) && m_busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget);
        int n;
        n = 0;
        while (!cond_met(which) && n < budget) begin
            cycle();
            n++;
        end
        check_val($sformatf("wait_%0d_reached", which), 64'(cond_met(which)), 64'd1);
    endtask

    // One-cycle reset pulse; a stray response is offered right after release.
    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check_val("rst_req_valid", imem_req_valid, 64'd0);
        check_val("rst_out_valid", out_valid, 64'd0);
        check_val("rst_inst_count", inst_count, 64'd0);
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_held   = 1'b0;
        m_pc     = RESET_PC;
        m_count  = 64'd0;
        mem_busy = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        check_val("post_rst_req_valid", imem_req_valid, 64'd1);
        check_val("post_rst_req_addr", imem_req_addr, RESET_PC);
        check_val("post_rst_out_valid", out_valid, 64'd0);
    endtask

    initial begin
        logic [63:0] saved_count;
        do_reset();

        // Back-to-back fetch with a 1-cycle memory: 4 handoffs in 12 cycles.
        run(12);
        #6;
        check_val("seq_count", inst_count, 64'd4);
        check_val("seq_next_addr", imem_req_addr, 64'h0000_0000_8000_0010);

        // Decode stalls for 5 cycles while an instruction is held.
        fixed_data = 1'b0;
        wait_for(0, 20);
        ov_out_ready = 0;
        run(5);
        ov_out_ready = -1;

        // Memory back-pressure for 4 cycles, then accept.
        wait_for(2, 20);
        ov_ready = 0;
        run(4);
        ov_ready = 1;
        run(1);
        ov_ready = -1;

        // Redirect during WAIT with a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        wait_for(2, 20);
        wait_for(1, 20);
        saved_count = m_count;
        ov_redir  = 1;
        ov_target = 64'h0000_0000_8000_1002;
        run(1);
        ov_redir = 0;
        wait_for(0, 30);
        #6;
        check_val("redir_wait_pc", out_pc, 64'h0000_0000_8000_1000);
        check_val("redir_wait_count", inst_count, saved_count);

        // Redirect in HOLD coinciding with out_ready.
        wait_for(0, 20);
        saved_count  = m_count;
        ov_redir     = 1;
        ov_target    = 64'h0000_0000_8000_2000;
        ov_out_ready = 1;
        run(1);
        ov_redir     = -1;
        ov_out_ready = -1;
        #6;
        check_val("redir_hold_count", inst_count, saved_count);
        check_val("redir_hold_addr", imem_req_addr, 64'h0000_0000_8000_2000);

        // Random traffic on all inputs.
        p_ready     = 70;
        p_out_ready = 70;
        p_redir     = 8;
        p_stray     = 3;
        lat_min     = 1;
        lat_max     = 4;
        run(3000);

        // Reset in WAIT with 7 instructions counted.
        p_redir = 0;
        p_stray = 0;
        do_reset();
        wait_for(3, 300);
        check_val("pre_reset_count", inst_count, 64'd7);
        do_reset();
        p_stray = 3;
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the single-issue RV64 core. It owns the program counter, issues one instruction-memory read at a time, buffers the returned 32-bit word, and hands it downstream to the decode/control stage together with its PC. The execute stage's redirect feeds back into it, so taken branches, `jal` and `jalr` steer the next fetch.

## Interface
Parameters:
- `RESET_PC`, default `64'h0000_0000_8000_0000`: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `imem_req_valid`, output, 1: fetch request valid.
- `imem_req_ready`, input, 1: memory accepts the request this cycle.
- `imem_req_addr`, output, 64: fetch address, always equal to the current `pc`.
- `imem_rsp_valid`, input, 1: read data valid. Asserted exactly once per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data`, input, 32: instruction word.
- `redirect_valid`, input, 1: control-flow change requested by execute.
- `redirect_target`, input, 64: new PC. Bits [1:0] are forced to 0 internally.
- `out_valid`, output, 1: instruction available to decode.
- `out_ready`, input, 1: decode consumes the instruction.
- `out_inst`, output, 32: buffered instruction. The decoder slices opcode [6:0] and func3 [14:12] from it.
- `out_pc`, output, 64: PC of `out_inst`.
- `inst_count`, output, 64: number of completed handoffs (`out_valid && out_ready` with no redirect that cycle).

## Operation
- Registers: `pc`, `state` ∈ {REQ, WAIT, HOLD}, `drop` flag, `inst_buf`, `pc_buf`, `inst_count`.
- REQ:
  - Drives `imem_req_valid = 1` and `imem_req_addr = pc`.
  - On `imem_req_ready`, go to WAIT and set `pc_buf = pc`.
- WAIT:
  - On `imem_rsp_valid` with `drop = 0`: capture `inst_buf = imem_rsp_data` and go to HOLD.
  - On `imem_rsp_valid` with `drop = 1`: discard the data, clear `drop`, and go to REQ.
- HOLD:
  - `out_valid = 1`, `out_inst = inst_buf`, `out_pc = pc_buf`.
  - On `out_ready`: set `pc = pc_buf + 4` (64-bit wrap), increment `inst_count` (64-bit wrap), and go to REQ.
- Redirect (highest priority; `pc <= {redirect_target[63:2], 2'b00}`):
  - In REQ without acceptance: `imem_req_addr` switches to the target next cycle. This is the only case in which an unaccepted request's address may change.
  - In REQ with `imem_req_ready` the same cycle: the old-PC request is issued, go to WAIT with `drop = 1`.
  - In WAIT without `imem_rsp_valid`: set `drop = 1` and stay in WAIT.
  - In WAIT with `imem_rsp_valid` the same cycle: discard the response, go to REQ.
  - In HOLD, including when `out_ready` is also 1: discard `inst_buf`, do not increment `inst_count`, go to REQ.
- At most one outstanding memory request, ever.
- `out_valid`, `out_inst` and `out_pc` remain stable while `out_valid = 1 && out_ready = 0`, unless a redirect occurs.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - `pc = RESET_PC`, `state = REQ`, `drop = 0`.
  - `inst_buf = 0`, `pc_buf = 0`, `inst_count = 0`.
  - `out_valid = 0`.
  - `imem_req_valid = 0` while `rst_n` is low; `imem_req_valid = 1` in the first cycle after deassertion.
- Latency:
  - Request accepted at cycle N, response at cycle N+k (k ≥ 1) → `out_valid` at N+k+1.
  - A handoff at cycle M → next `imem_req_valid` at M+1.
  - Peak throughput with k = 1: one instruction per 3 cycles.
- Redirect at cycle R → the target address is presented on `imem_req_addr` no later than the first cycle state is REQ after R. The wait for a dropped response is included.
- Reset asserted mid-WAIT: the pending response is the memory's responsibility to squash. After reset the block ignores any stray `imem_rsp_valid` while in REQ.
- `imem_rsp_valid` in REQ or HOLD is a protocol error and is ignored.

## Test plan
- Reset with `RESET_PC` = 0x80000000 and a 1-cycle memory returning 0x00000013 → first request addresses 0x80000000. `out_valid` is high at cycle 3 with `out_pc` = 0x80000000. Three further handoffs → PCs 0x80000004, 0x80000008, 0x8000000C and `inst_count` = 4.
- Hold `out_ready` = 0 for 5 cycles in HOLD → `out_inst`/`out_pc` stable, no new request, `inst_count` unchanged.
- Hold `imem_req_ready` = 0 for 4 cycles, then raise it → `imem_req_addr` stable throughout, and exactly one request is accepted.
- Redirect to 0x80001002 during WAIT with a 3-cycle memory → the stale response is discarded, `out_valid` never asserts for it, the next request goes to 0x80001000, and `inst_count` is unchanged.
- Redirect in HOLD in the same cycle as `out_ready` = 1 → the held instruction is not counted and the next request targets the redirect address.
- Pulse `rst_n` low for 1 cycle while in WAIT with `inst_count` = 7 → `out_valid` = 0 and `inst_count` = 0 immediately. Fetch restarts at `RESET_PC` and stray responses are ignored.
